// File: rtl/peripheral_dbg_soc_bb_arbiter.sv
// peripheral_dbg_soc_bb_arbiter
// Shares one Blackbone synchronous-SRAM port between NREQ CPU-side requesters
// and one debug (MAM) requester. Debug has fixed priority, CPU requesters are
// served round-robin. Ownership is registered; an owner keeps the port while
// its enable stays high, limited to MAX_HOLD accesses whenever others wait.
//
// Ports:
//   bb_clk_i, bb_rst_ni          clock, asynchronous active-low reset
//   req_addr/din/en/we_i         packed CPU requester buses (requester i at slice i)
//   req_gnt_o, req_rvalid_o      one-hot grant, per-requester read valid
//   req_dout_o                   broadcast read data
//   dbg_addr/din/en/we_i         MAM request
//   dbg_gnt_o, dbg_rvalid_o      MAM grant / read valid
//   dbg_dout_o                   MAM read data
//   mem_addr/din/en/we_o         memory macro request
//   mem_dout_i                   memory read data, one cycle after a read
//   conflict_cnt_o               only with PERIPHERAL_DBG_SOC_BB_ARB_STATS_EN defined:
//                                saturating count of cycles where an enabled
//                                requester is not the owner
module peripheral_dbg_soc_bb_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned NREQ     = 2,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             bb_clk_i,
    input  logic             bb_rst_ni,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_din_i,
    input  logic [NREQ-1:0]  req_en_i,
    input  logic [NREQ-1:0]  req_we_i,
    output logic [NREQ-1:0]  req_gnt_o,
    output logic [NREQ-1:0]  req_rvalid_o,
    output logic [DW-1:0]    req_dout_o,
    input  logic [AW-1:0]    dbg_addr_i,
    input  logic [DW-1:0]    dbg_din_i,
    input  logic             dbg_en_i,
    input  logic             dbg_we_i,
    output logic             dbg_gnt_o,
    output logic             dbg_rvalid_o,
    output logic [DW-1:0]    dbg_dout_o,
    output logic [AW-1:0]    mem_addr_o,
    output logic [DW-1:0]    mem_din_o,
    output logic             mem_en_o,
    output logic             mem_we_o,
    input  logic [DW-1:0]    mem_dout_i
`ifdef PERIPHERAL_DBG_SOC_BB_ARB_STATS_EN
    ,
    output logic [15:0]      conflict_cnt_o
`endif
);

    localparam int unsigned PtrW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {StIdle, StOwnDbg, StOwnReq} state_e;

    state_e            r_state;
    logic [PtrW-1:0]   r_owner;
    logic [PtrW-1:0]   r_ptr;
    logic [HoldW-1:0]  r_hold;
    logic [NREQ-1:0]   r_rv_req;
    logic              r_rv_dbg;

    logic              w_owner_en;
    logic              w_owner_we;
    logic [AW-1:0]     w_owner_addr;
    logic [DW-1:0]     w_owner_din;
    logic [NREQ-1:0]   w_gnt_req;
    logic              w_access;
    logic              w_other_pend;
    logic              w_expire;
    logic              w_arb;
    logic [NREQ-1:0]   w_cand_req;
    logic              w_cand_dbg;
    logic              w_rr_found;
    logic [PtrW-1:0]   w_rr_idx;
    logic [PtrW-1:0]   w_rr_scan;
    logic [PtrW-1:0]   w_rr_next;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_gnt_req[i] = (r_state == StOwnReq) && (32'(r_owner) == i);
        end
    end

    // Mux the current owner's request onto the memory port.
    always_comb begin
        w_owner_en   = 1'b0;
        w_owner_we   = 1'b0;
        w_owner_addr = '0;
        w_owner_din  = '0;
        unique case (r_state)
            StOwnDbg: begin
                w_owner_en   = dbg_en_i;
                w_owner_we   = dbg_we_i;
                w_owner_addr = dbg_addr_i;
                w_owner_din  = dbg_din_i;
            end
            StOwnReq: begin
                w_owner_en   = req_en_i[r_owner];
                w_owner_we   = req_we_i[r_owner];
                w_owner_addr = req_addr_i[r_owner*AW +: AW];
                w_owner_din  = req_din_i[r_owner*DW +: DW];
            end
            default: ;
        endcase
    end

    assign w_access = (r_state != StIdle) && w_owner_en;

    assign w_other_pend = (r_state == StOwnDbg) ? (|req_en_i)
                                                : (dbg_en_i || (|(req_en_i & ~w_gnt_req)));
    assign w_expire = w_access && (r_hold == HoldLast) && w_other_pend;
    assign w_arb    = (r_state == StIdle) || !w_owner_en || w_expire;

    // The current owner is never a candidate: either it released (en low)
    // or it expired and must step aside.
    assign w_cand_req = req_en_i & ~w_gnt_req;
    assign w_cand_dbg = dbg_en_i && (r_state != StOwnDbg);

    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_rr_scan  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_rr_scan = PtrW'((32'(r_ptr) + k) % NREQ);
            if (!w_rr_found && w_cand_req[w_rr_scan]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_rr_scan;
            end
        end
    end

    assign w_rr_next = PtrW'((32'(w_rr_idx) + 32'd1) % NREQ);

    always_ff @(posedge bb_clk_i or negedge bb_rst_ni) begin
        if (!bb_rst_ni) begin
            r_state  <= StIdle;
            r_owner  <= '0;
            r_ptr    <= '0;
            r_hold   <= '0;
            r_rv_req <= '0;
            r_rv_dbg <= 1'b0;
        end else begin
            // Read valid follows the access cycle, independent of later owner changes.
            r_rv_dbg <= w_access && (r_state == StOwnDbg) && !w_owner_we;
            r_rv_req <= (w_access && !w_owner_we) ? w_gnt_req : '0;
            if (w_arb) begin
                r_hold <= '0;
                if (w_cand_dbg) begin
                    r_state <= StOwnDbg;
                end else if (w_rr_found) begin
                    r_state <= StOwnReq;
                    r_owner <= w_rr_idx;
                    r_ptr   <= w_rr_next;
                end else begin
                    r_state <= StIdle;
                end
            end else if (w_access && (r_hold != HoldLast)) begin
                // Saturate so an uncontended stream expires on its next access
                // once someone else starts waiting.
                r_hold <= r_hold + HoldW'(1);
            end
        end
    end

    assign req_gnt_o    = w_gnt_req;
    assign req_rvalid_o = r_rv_req;
    assign req_dout_o   = mem_dout_i;
    assign dbg_gnt_o    = (r_state == StOwnDbg);
    assign dbg_rvalid_o = r_rv_dbg;
    assign dbg_dout_o   = mem_dout_i;
    assign mem_addr_o   = w_owner_addr;
    assign mem_din_o    = w_owner_din;
    assign mem_en_o     = w_access;
    assign mem_we_o     = w_owner_we;

`ifdef PERIPHERAL_DBG_SOC_BB_ARB_STATS_EN
    logic [15:0] r_conflict_cnt;
    logic        w_conflict;

    assign w_conflict = (dbg_en_i && (r_state != StOwnDbg)) || (|(req_en_i & ~w_gnt_req));

    always_ff @(posedge bb_clk_i or negedge bb_rst_ni) begin
        if (!bb_rst_ni) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt_o = r_conflict_cnt;
`endif

endmodule
